// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates the six conditional-branch conditions under a
// start/done handshake, produces the branch target and next PC, and keeps a table
// of 2-bit saturating counters with a combinational prediction port for fetch.
module branch_resolve_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pred_in,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    output logic            busy,
    output logic            done,
    output logic            taken,
    output logic            illegal,
    output logic            mispredict,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] next_pc
);

    localparam int IDX = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {IDLE, EVAL, WRITE} state_t;

    state_t            state_reg;
    logic [2:0]        func3_reg;
    logic [XLEN-1:0]   rs1_reg, rs2_reg, pc_reg, imm_reg;
    logic              pred_in_reg;
    logic              busy_reg, done_reg;
    logic              taken_reg, illegal_reg, mispredict_reg;
    logic [XLEN-1:0]   target_reg, next_pc_reg;

    logic              taken_next, illegal_next, mispredict_next;
    logic [XLEN-1:0]   target_next, next_pc_next;

    logic [1:0]        cnt_reg  [BHT_DEPTH];
    logic [1:0]        cnt_next [BHT_DEPTH];
    logic [IDX-1:0]    wr_idx;
    logic              cnt_we;

    // Condition evaluation and address arithmetic on the latched operands
    always_comb begin
        taken_next   = 1'b0;
        illegal_next = 1'b0;
        case (func3_reg)
            3'b000:  taken_next = (rs1_reg == rs2_reg);
            3'b001:  taken_next = (rs1_reg != rs2_reg);
            3'b100:  taken_next = ($signed(rs1_reg) <  $signed(rs2_reg));
            3'b101:  taken_next = ($signed(rs1_reg) >= $signed(rs2_reg));
            3'b110:  taken_next = (rs1_reg <  rs2_reg);
            3'b111:  taken_next = (rs1_reg >= rs2_reg);
            default: illegal_next = 1'b1;
        endcase
        target_next     = pc_reg + imm_reg;
        next_pc_next    = taken_next ? target_next : (pc_reg + XLEN'(4));
        mispredict_next = !illegal_next && (taken_next ^ pred_in_reg);
    end

    // Control FSM with operand latches and registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            taken_reg      <= 1'b0;
            illegal_reg    <= 1'b0;
            mispredict_reg <= 1'b0;
            target_reg     <= '0;
            next_pc_reg    <= '0;
            func3_reg      <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            pc_reg         <= '0;
            imm_reg        <= '0;
            pred_in_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        func3_reg   <= func3;
                        rs1_reg     <= rs1;
                        rs2_reg     <= rs2;
                        pc_reg      <= pc;
                        imm_reg     <= imm;
                        pred_in_reg <= pred_in;
                        busy_reg    <= 1'b1;
                        state_reg   <= EVAL;
                    end
                end
                EVAL: begin
                    taken_reg      <= taken_next;
                    illegal_reg    <= illegal_next;
                    mispredict_reg <= mispredict_next;
                    target_reg     <= target_next;
                    next_pc_reg    <= next_pc_next;
                    done_reg       <= 1'b1;
                    state_reg      <= WRITE;
                end
                WRITE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Counter write happens on the edge that leaves WRITE, only for legal branches
    assign wr_idx = pc_reg[IDX+1:2];
    assign cnt_we = (state_reg == WRITE) && !illegal_reg;

    // Per-entry saturating next value; only the addressed entry moves
    generate
        for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_cnt
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (cnt_we && (wr_idx == IDX'(gi))) begin
                    if (taken_reg) begin
                        if (cnt_reg[gi] != 2'b11) cnt_next[gi] = cnt_reg[gi] + 2'b01;
                    end else begin
                        if (cnt_reg[gi] != 2'b00) cnt_next[gi] = cnt_reg[gi] - 2'b01;
                    end
                end
            end
        end
    endgenerate

    // Counter table state; every entry returns to CNT_INIT on reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < BHT_DEPTH; i++) begin
            if (rst) cnt_reg[i] <= CNT_INIT;
            else     cnt_reg[i] <= cnt_next[i];
        end
    end

    // Prediction reads the current table, so a same-cycle write is not yet visible
    assign pred_taken = cnt_reg[pred_pc[IDX+1:2]][1];

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign taken      = taken_reg;
    assign illegal    = illegal_reg;
    assign mispredict = mispredict_reg;
    assign target     = target_reg;
    assign next_pc    = next_pc_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases followed by random
// branches, all checked against an arithmetic reference model of the branch rules.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, start, pred_in;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2, pc, imm, pred_pc;
    logic        pred_taken, busy, done, taken, illegal, mispredict;
    logic [31:0] target, next_pc;

    int checks = 0;
    int errors = 0;
    int bht [16];

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(16), .CNT_INIT(2'b01)) dut (
        .clk(clk), .rst(rst), .start(start), .func3(func3), .rs1(rs1), .rs2(rs2),
        .pc(pc), .imm(imm), .pred_in(pred_in), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .busy(busy), .done(done), .taken(taken),
        .illegal(illegal), .mispredict(mispredict), .target(target), .next_pc(next_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint as_signed(input logic [31:0] v);
        longint r;
        r = longint'(v);
        if (v >= 32'h8000_0000) r = r - 64'sd4294967296;
        return r;
    endfunction

    // Reference rule: returns taken, flags illegal for 010/011
    function automatic void ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output bit t, output bit ill);
        longint ua, ub, sa, sb;
        ua = longint'(a); ub = longint'(b);
        sa = as_signed(a); sb = as_signed(b);
        t = 0; ill = 0;
        case (f)
            3'd0: t = (ua == ub);
            3'd1: t = (ua != ub);
            3'd4: t = (sa <  sb);
            3'd5: t = (sa >= sb);
            3'd6: t = (ua <  ub);
            3'd7: t = (ua >= ub);
            default: ill = 1;
        endcase
    endfunction

    function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] s;
        s = {32'd0, a} + {32'd0, b};
        return s[31:0];
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht[i] = 1;
    endtask

    // One full branch: start, EVAL, WRITE, then the cycle after the counter write
    task automatic do_branch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] p, input logic [31:0] im, input bit pin);
        bit t, ill;
        logic [31:0] tgt, npc;
        int k;
        ref_cond(f, a, b, t, ill);
        tgt = wrap_add(p, im);
        npc = t ? tgt : wrap_add(p, 32'd4);
        k = idx_of(p);
        @(negedge clk);
        func3 = f; rs1 = a; rs2 = b; pc = p; imm = im; pred_in = pin; pred_pc = p; start = 1;
        @(posedge clk); #1;
        start = 0;
        // scramble inputs: the unit must work from its latched copies
        func3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; pc = $urandom; imm = $urandom;
        pred_in = ~pin;
        chk("busy_eval", {31'd0, busy}, 32'd1);
        chk("done_eval", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        chk("done", {31'd0, done}, 32'd1);
        chk("taken", {31'd0, taken}, {31'd0, t});
        chk("illegal", {31'd0, illegal}, {31'd0, ill});
        chk("mispredict", {31'd0, mispredict}, {31'd0, (!ill) && (t != pin)});
        chk("target", target, tgt);
        chk("next_pc", next_pc, npc);
        chk("pred_pre", {31'd0, pred_taken}, {31'd0, bht[k] >= 2});
        if (!ill) begin
            if (t) bht[k] = (bht[k] < 3) ? bht[k] + 1 : 3;
            else   bht[k] = (bht[k] > 0) ? bht[k] - 1 : 0;
        end
        @(posedge clk); #1;
        chk("done_after", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("pred_post", {31'd0, pred_taken}, {31'd0, bht[k] >= 2});
        $display("branch f3=%0d rs1=%h rs2=%h pc=%h imm=%h pin=%0d -> taken=%0d ill=%0d tgt=%h npc=%h",
                 f, a, b, p, im, pin, t, ill, tgt, npc);
    endtask

    initial begin
        int ndone;
        bit t0, i0;
        logic [31:0] a, b, p;
        rst = 1; start = 0; func3 = 0; rs1 = 0; rs2 = 0; pc = 0; imm = 0; pred_in = 0;
        pred_pc = 32'h40;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_next_pc", next_pc, 32'd0);

        // BEQ taken, predicted not-taken
        do_branch(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        pred_pc = 32'h100; #1;
        chk("beq_pred_later", {31'd0, pred_taken}, 32'd1);

        // Signed vs unsigned comparisons
        do_branch(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b1);
        do_branch(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h304, 32'h10, 1'b1);
        do_branch(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h308, 32'h10, 1'b0);
        do_branch(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h30C, 32'h10, 1'b0);
        do_branch(3'b001, 32'd7, 32'd7, 32'h310, 32'h10, 1'b0);

        // Saturation: four taken then one not-taken at 0x200
        for (int i = 0; i < 4; i++) do_branch(3'b000, 32'd9, 32'd9, 32'h200, 32'h40, 1'b1);
        do_branch(3'b001, 32'd9, 32'd9, 32'h200, 32'h40, 1'b1);
        chk("sat_model", bht[idx_of(32'h200)], 32'd2);

        // Illegal encodings and address wrap
        do_branch(3'b010, 32'd1, 32'd2, 32'h400, 32'h80, 1'b1);
        do_branch(3'b011, 32'd3, 32'd3, 32'h404, 32'h80, 1'b0);
        do_branch(3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b1);

        // Reset during EVAL aborts the branch and restores the table
        @(negedge clk);
        func3 = 3'b000; rs1 = 1; rs2 = 1; pc = 32'h100; imm = 4; pred_in = 0; start = 1;
        @(posedge clk); #1;
        start = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        pred_pc = 32'h100; #1;
        chk("abort_pred", {31'd0, pred_taken}, 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 32'd0);
        $display("abort: reset in EVAL, dones seen=%0d", ndone);

        // start held high through busy: exactly one done per accepted start
        @(negedge clk);
        func3 = 3'b001; rs1 = 1; rs2 = 2; pc = 32'h500; imm = 32'h100; pred_in = 0; start = 1;
        ndone = 0;
        @(posedge clk); #1;          // accepted
        pc = 32'h600; rs2 = 1;       // start still high, must be ignored while busy
        @(posedge clk); #1;
        if (done) ndone++;
        chk("hold_target", target, 32'h600);
        @(posedge clk); #1;
        if (done) ndone++;
        start = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("hold_one_done", ndone, 32'd1);
        bht[idx_of(32'h500)] = 2;
        pred_pc = 32'h500; #1;
        chk("hold_pred", {31'd0, pred_taken}, 32'd1);
        $display("hold-start: dones seen=%0d", ndone);

        // Random branches over a small PC window so counters are revisited
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]};
            p = 32'h1000 + ({28'd0, 4'($urandom)} << 2);
            do_branch(3'($urandom), a, b, p, $urandom, 1'($urandom));
        end
        ref_cond(3'b100, 32'h8000_0000, 32'h7FFF_FFFF, t0, i0);
        chk("model_signed_min", {31'd0, t0}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
